// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the LCD writer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    HOLD,
    IDLE
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_HOME_ADDR = 8'h80;

  localparam int         INIT_STEPS = 5;
  localparam logic [2:0] LAST_STEP  = 3'(INIT_STEPS - 1);

  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    case (step)
      3'd0:    return LCD_FUNC_SET;
      3'd1:    return LCD_DISP_ON;
      3'd2:    return LCD_CLEAR;
      3'd3:    return LCD_ENTRY;
      default: return LCD_HOME_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_char_rom.sv
// Message ROM: 4-bit index to ASCII for "HELLO FPGA LCD! ".
module lcd_char_rom (
  input  logic [3:0] index_i,
  output logic [7:0] char_o
);

  always_comb begin
    char_o = 8'h20;
    case (index_i)
      4'd0:    char_o = 8'h48; // H
      4'd1:    char_o = 8'h45; // E
      4'd2:    char_o = 8'h4C; // L
      4'd3:    char_o = 8'h4C; // L
      4'd4:    char_o = 8'h4F; // O
      4'd5:    char_o = 8'h20;
      4'd6:    char_o = 8'h46; // F
      4'd7:    char_o = 8'h50; // P
      4'd8:    char_o = 8'h47; // G
      4'd9:    char_o = 8'h41; // A
      4'd10:   char_o = 8'h20;
      4'd11:   char_o = 8'h4C; // L
      4'd12:   char_o = 8'h43; // C
      4'd13:   char_o = 8'h44; // D
      4'd14:   char_o = 8'h21; // !
      default: char_o = 8'h20;
    endcase
  end

endmodule

// File: rtl/lcd_writer.sv
// HD44780 8-bit writer: power-up init sequence, then one timed write per accepted index.
//   state    | meaning
//   PWR_WAIT | power-up delay before first init command
//   SETUP    | RS/DB driven, enable low, one cycle
//   PULSE    | enable high for E_PULSE_CYC cycles
//   HOLD     | enable low, command execution wait
//   IDLE     | ready to accept data_ready
module lcd_writer
  import lcd_pkg::*;
#(
  parameter int unsigned E_PULSE_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000,
  parameter int unsigned POWERUP_CYC    = 2000000
) (
  input  logic       clk,
  input  logic       reset_button,
  input  logic       data_ready,
  input  logic [3:0] data_index,
  output logic       lcd_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned CNT_MAX =
    (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          busy_q, en_q;
  logic [CW-1:0] hold_last;
  logic [7:0]    rom_char;

  lcd_char_rom u_rom (
    .index_i (data_index),
    .char_o  (rom_char)
  );

  // Only the clear command (never a character) needs the long wait.
  assign hold_last = (!rs_q && data_q == LCD_CLEAR) ? CLEAR_LAST : CMD_LAST;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    rs_d    = rs_q;
    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = SETUP;
          step_d  = 3'd0;
          data_d  = init_cmd(3'd0);
          rs_d    = 1'b0;
        end
      end
      SETUP: state_d = PULSE;
      PULSE: begin
        if (cnt_q == EN_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == hold_last) begin
          if (rs_q || step_q == LAST_STEP) begin
            state_d = IDLE;
          end else begin
            step_d  = step_q + 3'd1;
            data_d  = init_cmd(step_q + 3'd1);
            state_d = SETUP;
          end
        end
      end
      IDLE: begin
        if (data_ready) begin
          data_d  = rom_char;
          rs_d    = 1'b1;
          state_d = SETUP;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  // Busy and enable are registered from next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset_button) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      step_q  <= 3'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      busy_q  <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      busy_q  <= (state_d != IDLE);
      en_q    <= (state_d == PULSE);
    end
  end

  assign lcd_busy = busy_q;
  assign lcd_en   = en_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed self-checking bench for lcd_writer with shortened timing parameters.
module tb_lcd_writer;

  logic       clk = 1'b0;
  logic       reset_button = 1'b1;
  logic       data_ready = 1'b0;
  logic [3:0] data_index = 4'd0;
  logic       lcd_busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] rom_exp [16] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h46, 8'h50,
                               8'h47, 8'h41, 8'h20, 8'h4C, 8'h43, 8'h44, 8'h21, 8'h20};
  logic [7:0] init_exp [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

  lcd_writer #(
    .E_PULSE_CYC    (2),
    .CMD_WAIT_CYC   (4),
    .CLEAR_WAIT_CYC (8),
    .POWERUP_CYC    (10)
  ) dut (
    .clk          (clk),
    .reset_button (reset_button),
    .data_ready   (data_ready),
    .data_index   (data_index),
    .lcd_busy     (lcd_busy),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_data     (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (lcd_busy && c < 200) begin
      tick();
      c++;
    end
    check({tag, " idle_timeout"}, int'(lcd_busy), 0);
  endtask

  // Called at the negedge where reset_button was just dropped; k counts edges after release.
  task automatic run_init(input string tag);
    int   pulses = 0;
    int   width = 0;
    int   fall_at = -1;
    int   rs_viol = 0;
    logic prev_en = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (lcd_en) begin
        if (!prev_en) begin
          if (pulses < 5) check({tag, " init_cmd"}, int'(lcd_data), int'(init_exp[pulses]));
          pulses++;
          width = 0;
        end
        width++;
      end else if (prev_en) begin
        check({tag, " en_width"}, width, 2);
      end
      if (lcd_rs) rs_viol++;
      prev_en = lcd_en;
      if (!lcd_busy) begin
        fall_at = k;
        break;
      end
    end
    check({tag, " pulse_count"}, pulses, 5);
    check({tag, " busy_fall"}, fall_at, 49);
    check({tag, " rs_during_init"}, rs_viol, 0);
  endtask

  // Called at the negedge just after the accept edge (cycle 1).
  task automatic capture_write(input string tag, input logic [7:0] exp_char);
    logic [15:0] bm = '0;
    logic [15:0] em = '0;
    bm[1] = lcd_busy;
    em[1] = lcd_en;
    check({tag, " data"}, int'(lcd_data), int'(exp_char));
    check({tag, " rs"}, int'(lcd_rs), 1);
    for (int k = 2; k <= 12; k++) begin
      tick();
      bm[k] = lcd_busy;
      em[k] = lcd_en;
      if (k == 3) check({tag, " data_stable"}, int'(lcd_data), int'(exp_char));
    end
    check({tag, " busy_window"}, int'(bm), 16'h00FE);
    check({tag, " en_window"}, int'(em), 16'h000C);
  endtask

  task automatic do_write(input string tag, input logic [3:0] idx, input logic [7:0] exp_char);
    wait_idle(tag);
    data_index = idx;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    capture_write(tag, exp_char);
  endtask

  initial begin
    int idx;
    int en_rises;
    int busy_hi;
    logic prev_en;

    repeat (3) tick();
    check("reset busy", int'(lcd_busy), 1);
    check("reset en", int'(lcd_en), 0);
    check("reset rs", int'(lcd_rs), 0);
    check("reset rw", int'(lcd_rw), 0);
    check("reset data", int'(lcd_data), 0);

    // 1: power-up init
    reset_button = 1'b0;
    run_init("t1");

    // 2: single character write, index 0
    do_write("t2", 4'd0, 8'h48);

    // 3: data_ready held through reset and init
    reset_button = 1'b1;
    data_index   = 4'd3;
    data_ready   = 1'b1;
    repeat (2) tick();
    reset_button = 1'b0;
    run_init("t3");
    tick();
    data_ready = 1'b0;
    capture_write("t3", 8'h4C);

    // 4: reset during PULSE of a character write
    wait_idle("t4");
    data_index = 4'd0;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
    check("t4 en_before_reset", int'(lcd_en), 1);
    reset_button = 1'b1;
    tick();
    check("t4 en_after_reset", int'(lcd_en), 0);
    check("t4 busy_after_reset", int'(lcd_busy), 1);
    check("t4 data_after_reset", int'(lcd_data), 0);
    reset_button = 1'b0;
    run_init("t4");

    // 5: closed loop with a controller model that halts at index 15
    idx = 0;
    for (int n = 0; n < 15; n++) begin
      wait_idle("t5");
      data_index = 4'(idx);
      data_ready = 1'b1;
      tick();
      if (lcd_busy && data_ready) idx++;
      data_ready = 1'b0;
      capture_write("t5", rom_exp[n]);
    end
    check("t5 final_index", idx, 15);
    data_index = 4'(idx);
    en_rises = 0;
    busy_hi  = 0;
    prev_en  = lcd_en;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (lcd_en && !prev_en) en_rises++;
      if (lcd_busy) busy_hi++;
      prev_en = lcd_en;
    end
    check("t5 no_extra_strobes", en_rises, 0);
    check("t5 busy_stays_low", busy_hi, 0);

    // 6: forced index 15
    do_write("t6", 4'd15, 8'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
